// File: rtl/shift_ctrl_pkg.sv
// Shared state encodings and shift-direction constants for the shift frame controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Host/serial-line bundle of the shift frame controller; master = host side, slave = controller.
interface shift_frame_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] tx_data;
  logic             si;
  logic             so;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output start, dir, tx_data, si,
    input  so, busy, done, rx_data
  );

  modport slave (
    input  start, dir, tx_data, si,
    output so, busy, done, rx_data
  );

endinterface

// File: rtl/shift_r_ld.sv
// WIDTH-bit bidirectional shift register with parallel load; load has priority over shift.
module shift_r_ld
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             si,
  input  logic             left_right,
  output logic [WIDTH-1:0] po
);

  // Register update: clear, load, or one-position shift with si entering the vacated end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po <= {WIDTH{1'b0}};
    end else if (load) begin
      po <= d;
    end else if (en) begin
      if (left_right == DIR_RIGHT) begin
        po <= {si, po[WIDTH-1:1]};
      end else begin
        po <= {po[WIDTH-2:0], si};
      end
    end else begin
      po <= po;
    end
  end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Frame sequencer: loads a word, shifts it out one bit per DIV clocks while capturing si,
// and presents the captured word on rx_data with a one-cycle done pulse.
module shift_frame_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_frame_ctrl_if.slave    bus
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t           state_r;
  logic             dir_r;
  logic [DW-1:0]    div_cnt_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] rx_data_r;
  logic [WIDTH-1:0] shreg_s;
  logic [WIDTH-1:0] shift_next_s;
  logic             load_s;
  logic             en_s;
  logic             div_last_s;
  logic             last_bit_s;
  logic             so_s;

  shift_r_ld #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .d          (bus.tx_data),
    .en         (en_s),
    .si         (bus.si),
    .left_right (dir_r),
    .po         (shreg_s)
  );

  // Control decodes plus the post-shift value so rx_data can be captured on the final shift edge.
  always_comb begin
    load_s       = (state_r == ST_IDLE) && bus.start;
    div_last_s   = (div_cnt_r == DW'(DIV - 1));
    en_s         = (state_r == ST_SHIFT) && div_last_s;
    last_bit_s   = (bit_cnt_r == BW'(WIDTH - 1));
    shift_next_s = shreg_s;
    so_s         = 1'b0;
    if (dir_r == DIR_RIGHT) begin
      shift_next_s = {bus.si, shreg_s[WIDTH-1:1]};
    end else begin
      shift_next_s = {shreg_s[WIDTH-2:0], bus.si};
    end
    if (state_r == ST_SHIFT) begin
      so_s = (dir_r == DIR_RIGHT) ? shreg_s[0] : shreg_s[WIDTH-1];
    end else begin
      so_s = 1'b0;
    end
  end

  // Frame FSM with bit-period and bit counters; an abort by reset never reaches DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      dir_r     <= DIR_LEFT;
      div_cnt_r <= {DW{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      rx_data_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r   <= ST_SHIFT;
            dir_r     <= bus.dir;
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (div_last_s) begin
            div_cnt_r <= {DW{1'b0}};
            bit_cnt_r <= bit_cnt_r + BW'(1);
            if (last_bit_s) begin
              state_r   <= ST_DONE;
              rx_data_r <= shift_next_s;
            end else begin
              state_r <= ST_SHIFT;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.so      = so_s;
  assign bus.busy    = (state_r == ST_SHIFT) || (state_r == ST_DONE);
  assign bus.done    = (state_r == ST_DONE);
  assign bus.rx_data = rx_data_r;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench: directed vector table, reset/abort and back-to-back sequences, random frames.
module tb_shift_frame_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_frame_ctrl_if #(.WIDTH(W)) b1 ();
  shift_frame_ctrl_if #(.WIDTH(W)) b4 ();

  shift_frame_ctrl #(.WIDTH(W), .DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  shift_frame_ctrl #(.WIDTH(W), .DIV(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  typedef struct {
    int           w;
    logic [W-1:0] tx;
    logic         dir;
    int           si_mode;   // 0 random, 1 loopback, 2 const 1, 3 const 0
    bit           mid;
    logic [W-1:0] exp_so;    // first bit out at [W-1]
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic so_of(input int w);
    return (w == 1) ? b1.so : b4.so;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 1) ? b1.busy : b4.busy;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 1) ? b1.done : b4.done;
  endfunction

  function automatic logic [W-1:0] rx_of(input int w);
    return (w == 1) ? b1.rx_data : b4.rx_data;
  endfunction

  task automatic set_in(input int w, input logic st, input logic d, input logic [W-1:0] tx,
                        input logic s);
    if (w == 1) begin
      b1.start = st; b1.dir = d; b1.tx_data = tx; b1.si = s;
    end else begin
      b4.start = st; b4.dir = d; b4.tx_data = tx; b4.si = s;
    end
  endtask

  // Called #1 after a posedge with the selected DUT idle; returns #1 after the edge leaving DONE.
  task automatic run_frame(input int w, input logic [W-1:0] tx, input logic dir,
                           input int si_mode, input bit hold, input bit mid,
                           output logic [W-1:0] so_seq, output logic [W-1:0] rx_got);
    int           div;
    int           j;
    logic [W-1:0] exp_rx;
    logic         si;
    logic         so_now;
    logic         mid_now;
    div    = (w == 1) ? 1 : 4;
    exp_rx = '0;
    so_seq = '0;
    si     = 1'b0;
    set_in(w, 1'b1, dir, tx, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < W * div; c++) begin
      j      = c / div;
      so_now = so_of(w);
      chk1("busy_in_frame", busy_of(w), 1'b1);
      chk1("done_in_frame", done_of(w), 1'b0);
      chk1("so_bit", so_now, dir ? tx[j] : tx[W-1-j]);
      if (c % div == 0) begin
        so_seq[W-1-j] = so_now;
        case (si_mode)
          0:       si = 1'($urandom_range(0, 1));
          1:       si = so_now;
          2:       si = 1'b1;
          default: si = 1'b0;
        endcase
        if (dir) exp_rx[j] = si;
        else     exp_rx[W-1-j] = si;
      end
      mid_now = mid && (c == (W * div) / 2);
      set_in(w, mid_now ? 1'b1 : hold, ~dir, mid_now ? '0 : W'($urandom), si);
      @(posedge clk); #1;
    end
    chk1("done_pulse", done_of(w), 1'b1);
    chk1("busy_in_done", busy_of(w), 1'b1);
    chk1("so_in_done", so_of(w), 1'b0);
    rx_got = rx_of(w);
    chk8("rx_model", rx_got, exp_rx);
    set_in(w, hold, dir, tx, 1'b0);
    @(posedge clk); #1;
    chk1("busy_after_done", busy_of(w), 1'b0);
    chk1("done_single", done_of(w), 1'b0);
    chk1("so_idle", so_of(w), 1'b0);
    chk8("rx_hold", rx_of(w), exp_rx);
  endtask

  initial begin
    logic [W-1:0] so_seq;
    logic [W-1:0] rx_got;
    int           w;

    vecs[0] = '{1, 8'hA5, 1'b1, 1, 1'b0, 8'b10100101, 8'hA5};
    vecs[1] = '{4, 8'h81, 1'b0, 2, 1'b0, 8'b10000001, 8'hFF};
    vecs[2] = '{4, 8'h3C, 1'b1, 3, 1'b1, 8'b00111100, 8'h00};
    vecs[3] = '{1, 8'hC3, 1'b0, 1, 1'b0, 8'b11000011, 8'hC3};
    vecs[4] = '{4, 8'h01, 1'b1, 2, 1'b0, 8'b10000000, 8'hFF};
    vecs[5] = '{1, 8'h5A, 1'b0, 3, 1'b1, 8'b01011010, 8'h00};

    // Reset held with start asserted: nothing may start.
    set_in(1, 1'b1, 1'b1, 8'hFF, 1'b1);
    set_in(4, 1'b1, 1'b0, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_so", b4.so, 1'b0);
    chk1("rst_busy", b4.busy, 1'b0);
    chk1("rst_done", b4.done, 1'b0);
    chk8("rst_rx", b4.rx_data, 8'h00);
    chk1("rst_busy_div1", b1.busy, 1'b0);
    set_in(1, 1'b0, 1'b0, 8'h00, 1'b0);
    set_in(4, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("idle_after_rst", b4.busy, 1'b0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].w, vecs[i].tx, vecs[i].dir, vecs[i].si_mode, 1'b0, vecs[i].mid,
                so_seq, rx_got);
      chk8($sformatf("vec%0d_so_seq", i), so_seq, vecs[i].exp_so);
      chk8($sformatf("vec%0d_rx", i), rx_got, vecs[i].exp_rx);
    end

    // Abort by reset after three bits of a DIV=4 frame.
    set_in(4, 1'b1, 1'b0, 8'hF0, 1'b1);
    @(posedge clk); #1;
    set_in(4, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3 * 4) @(posedge clk);
    #1;
    chk1("abort_busy_before", b4.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_busy", b4.busy, 1'b0);
    chk1("abort_so", b4.so, 1'b0);
    chk1("abort_done", b4.done, 1'b0);
    chk8("abort_rx", b4.rx_data, 8'h00);
    chk8("abort_rx_div1", b1.rx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk1("abort_no_done", b4.done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 8'h96, 1'b1, 2, 1'b0, 1'b0, so_seq, rx_got);
    chk8("post_abort_so_seq", so_seq, 8'b01101001);
    chk8("post_abort_rx", rx_got, 8'hFF);

    // Start held high: back-to-back frames with a single idle cycle between them.
    run_frame(4, 8'h12, 1'b0, 0, 1'b1, 1'b0, so_seq, rx_got);
    run_frame(4, 8'h34, 1'b1, 0, 1'b1, 1'b0, so_seq, rx_got);
    run_frame(4, 8'h56, 1'b0, 1, 1'b0, 1'b0, so_seq, rx_got);
    chk8("held_last_rx", rx_got, 8'h56);

    // Randomized frames against the model.
    for (int r = 0; r < 16; r++) begin
      w = ($urandom_range(0, 1) == 0) ? 1 : 4;
      run_frame(w, W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                1'b0, 1'($urandom_range(0, 1)), so_seq, rx_got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
